// File: rtl/uart_alu_top_if.sv
// Serial line bundle between a UART host (master) and the ALU device (slave).
interface uart_alu_top_if;
    logic rx;
    logic tx;

    modport master (output rx, input tx);
    modport slave  (input rx, output tx);
endinterface

// File: rtl/uart_alu_top.sv
// UART-controlled 8-bit ALU: receives A, B and opcode as 8N1 bytes and returns the result byte.
module uart_alu_baud #(
    parameter int BAUD_DIV = 326
) (
    input  logic i_clk,
    input  logic i_reset,
    output logic tick
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            count <= '0;
        else if (count == CW'(BAUD_DIV - 1))
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == CW'(BAUD_DIV - 1));
endmodule

module uart_alu_rx #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    uart_alu_top_if.slave      line,
    output logic               rx_done,
    output logic [NB_DATA-1:0] rx_data
);
    localparam int SW = $clog2(SB_TICK);
    localparam int NW = $clog2(NB_DATA);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    rx_state_e          state, state_next;
    logic [SW-1:0]      s_cnt, s_next;
    logic [NW-1:0]      n_cnt, n_next;
    logic [NB_DATA-1:0] shift, shift_next;
    logic [1:0]         sync;
    logic               rx_s;

    assign rx_s = sync[1];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            s_cnt <= '0;
            n_cnt <= '0;
            shift <= '0;
            sync  <= 2'b11;
        end else begin
            state <= state_next;
            s_cnt <= s_next;
            n_cnt <= n_next;
            shift <= shift_next;
            sync  <= {sync[0], line.rx};
        end
    end

    // Start bit is re-checked mid-bit so a short low glitch falls back to IDLE.
    always_comb begin
        state_next = state;
        s_next     = s_cnt;
        n_next     = n_cnt;
        shift_next = shift;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s_cnt == SW'(SB_TICK / 2 - 1)) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = rx_s ? IDLE : DATA;
                    end else
                        s_next = s_cnt + 1'b1;
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s_cnt == SW'(SB_TICK - 1)) begin
                        s_next     = '0;
                        shift_next = {rx_s, shift[NB_DATA-1:1]};
                        if (n_cnt == NW'(NB_DATA - 1))
                            state_next = STOP;
                        else
                            n_next = n_cnt + 1'b1;
                    end else
                        s_next = s_cnt + 1'b1;
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (s_cnt == SW'(SB_TICK - 1))
                        state_next = IDLE;
                    else
                        s_next = s_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_done = (state == STOP) && i_tick && (s_cnt == SW'(SB_TICK - 1));
    end

    assign rx_data = shift;
endmodule

module uart_alu_tx #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               tx_start,
    input  logic [NB_DATA-1:0] tx_data,
    uart_alu_top_if.slave      line,
    output logic               tx_done
);
    localparam int SW = $clog2(SB_TICK);
    localparam int NW = $clog2(NB_DATA);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    tx_state_e          state, state_next;
    logic [SW-1:0]      s_cnt, s_next;
    logic [NW-1:0]      n_cnt, n_next;
    logic [NB_DATA-1:0] shift, shift_next;
    logic               tx_reg, tx_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            s_cnt  <= '0;
            n_cnt  <= '0;
            shift  <= '0;
            tx_reg <= 1'b1;
        end else begin
            state  <= state_next;
            s_cnt  <= s_next;
            n_cnt  <= n_next;
            shift  <= shift_next;
            tx_reg <= tx_next;
        end
    end

    always_comb begin
        state_next = state;
        s_next     = s_cnt;
        n_next     = n_cnt;
        shift_next = shift;
        tx_next    = tx_reg;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (tx_start) begin
                    state_next = START;
                    s_next     = '0;
                    shift_next = tx_data;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (i_tick) begin
                    if (s_cnt == SW'(SB_TICK - 1)) begin
                        state_next = DATA;
                        s_next     = '0;
                        n_next     = '0;
                    end else
                        s_next = s_cnt + 1'b1;
                end
            end
            DATA: begin
                tx_next = shift[0];
                if (i_tick) begin
                    if (s_cnt == SW'(SB_TICK - 1)) begin
                        s_next     = '0;
                        shift_next = shift >> 1;
                        if (n_cnt == NW'(NB_DATA - 1))
                            state_next = STOP;
                        else
                            n_next = n_cnt + 1'b1;
                    end else
                        s_next = s_cnt + 1'b1;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (i_tick) begin
                    if (s_cnt == SW'(SB_TICK - 1))
                        state_next = IDLE;
                    else
                        s_next = s_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_done = (state == STOP) && i_tick && (s_cnt == SW'(SB_TICK - 1));
    end

    assign line.tx = tx_reg;
endmodule

module uart_alu_ctrl #(
    parameter int NB_DATA  = 8,
    parameter int NB_CODE  = 6,
    parameter int NB_STATE = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               rx_done,
    input  logic [NB_DATA-1:0] rx_data,
    input  logic               tx_done,
    output logic               tx_start,
    output logic [NB_DATA-1:0] tx_data
);
    typedef enum logic [NB_STATE-1:0] {WAIT_A, WAIT_B, WAIT_OP, SEND} ctrl_state_e;

    localparam logic [NB_CODE-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_CODE-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_CODE-1:0] OP_AND = 6'b100100;
    localparam logic [NB_CODE-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_CODE-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_CODE-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_CODE-1:0] OP_SRL = 6'b000010;
    localparam logic [NB_CODE-1:0] OP_NOR = 6'b100111;

    ctrl_state_e        state, state_next;
    logic [NB_DATA-1:0] a_reg, a_next, b_reg, b_next;
    logic [NB_CODE-1:0] op_reg, op_next;
    logic               sent, start_now;
    logic [NB_DATA-1:0] alu_result;
    logic               unused_code_bits;

    assign unused_code_bits = ^rx_data[NB_DATA-1:NB_CODE];

    // sent delays tx_start by one cycle after entering SEND and keeps it to a single pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= WAIT_A;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            sent     <= 1'b0;
            tx_start <= 1'b0;
        end else begin
            state    <= state_next;
            a_reg    <= a_next;
            b_reg    <= b_next;
            op_reg   <= op_next;
            sent     <= (state == SEND);
            tx_start <= start_now;
        end
    end

    always_comb begin
        state_next = state;
        a_next     = a_reg;
        b_next     = b_reg;
        op_next    = op_reg;
        case (state)
            WAIT_A:  if (rx_done) begin a_next = rx_data; state_next = WAIT_B; end
            WAIT_B:  if (rx_done) begin b_next = rx_data; state_next = WAIT_OP; end
            WAIT_OP: if (rx_done) begin op_next = rx_data[NB_CODE-1:0]; state_next = SEND; end
            SEND:    if (tx_done) state_next = WAIT_A;
            default: state_next = WAIT_A;
        endcase
    end

    always_comb begin
        start_now = (state == SEND) && !sent;
    end

    // Shift amount is the whole B byte, so large amounts drain to zero or sign fill.
    always_comb begin
        case (op_reg)
            OP_ADD:  alu_result = a_reg + b_reg;
            OP_SUB:  alu_result = a_reg - b_reg;
            OP_AND:  alu_result = a_reg & b_reg;
            OP_OR:   alu_result = a_reg | b_reg;
            OP_XOR:  alu_result = a_reg ^ b_reg;
            OP_SRA:  alu_result = $signed(a_reg) >>> b_reg;
            OP_SRL:  alu_result = a_reg >> b_reg;
            OP_NOR:  alu_result = ~(a_reg | b_reg);
            default: alu_result = '0;
        endcase
    end

    assign tx_data = alu_result;
endmodule

module uart_alu_top #(
    parameter int NB_DATA  = 8,
    parameter int SB_TICK  = 16,
    parameter int NB_CODE  = 6,
    parameter int NB_STATE = 2,
    parameter int BAUD_DIV = 326
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_rx,
    output logic o_tx
);
    uart_alu_top_if serial ();

    logic               tick, rx_done, tx_start, tx_done;
    logic [NB_DATA-1:0] rx_data, tx_data;

    assign serial.rx = i_rx;
    assign o_tx      = serial.tx;

    uart_alu_baud #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .i_clk(i_clk), .i_reset(i_reset), .tick(tick)
    );

    uart_alu_rx #(.NB_DATA(NB_DATA), .SB_TICK(SB_TICK)) u_rx (
        .i_clk(i_clk), .i_reset(i_reset), .i_tick(tick), .line(serial),
        .rx_done(rx_done), .rx_data(rx_data)
    );

    uart_alu_tx #(.NB_DATA(NB_DATA), .SB_TICK(SB_TICK)) u_tx (
        .i_clk(i_clk), .i_reset(i_reset), .i_tick(tick), .tx_start(tx_start),
        .tx_data(tx_data), .line(serial), .tx_done(tx_done)
    );

    uart_alu_ctrl #(.NB_DATA(NB_DATA), .NB_CODE(NB_CODE), .NB_STATE(NB_STATE)) u_ctrl (
        .i_clk(i_clk), .i_reset(i_reset), .rx_done(rx_done), .rx_data(rx_data),
        .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data)
    );
endmodule

// File: tb/tb_uart_alu_top.sv
// Loopback bench: sends 8N1 operand/opcode bytes, decodes the returned byte and scoreboards it.
module tb_uart_alu_top;
    localparam int BAUD_DIV = 2;
    localparam int BIT_CLKS = 16 * BAUD_DIV;
    localparam int WAIT_MAX = 2000;

    logic i_clk = 1'b0;
    logic i_reset;

    uart_alu_top_if serial ();

    uart_alu_top #(.BAUD_DIV(BAUD_DIV)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_rx(serial.rx),
        .o_tx(serial.tx)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         checks   = 0;
    int         failures = 0;

    // Decodes every frame seen on tx by sampling mid-bit.
    initial begin : tx_monitor
        logic [7:0] data;
        forever begin
            @(negedge i_clk);
            if (serial.tx === 1'b0) begin
                repeat (BIT_CLKS / 2) @(negedge i_clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CLKS) @(negedge i_clk);
                    data[i] = serial.tx;
                end
                repeat (BIT_CLKS) @(negedge i_clk);
                rx_q.push_back(data);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int nbits);
        logic [9:0] frame;
        frame = {1'b1, data, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            serial.rx = frame[i];
            repeat (BIT_CLKS) @(negedge i_clk);
        end
        serial.rx = 1'b1;
        repeat (8) @(negedge i_clk);
    endtask

    task automatic waitResult(input string tag);
        int cycles;
        cycles = 0;
        while (rx_q.size() == 0 && cycles < WAIT_MAX) begin
            @(negedge i_clk);
            cycles++;
        end
        if (rx_q.size() == 0) begin
            checks++;
            assert (rx_q.size() != 0) else begin
                failures++;
                $error("[TB] FAIL %s observed=no_byte expected=one_byte_within_%0d_clocks", tag, WAIT_MAX);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s observed=0x%02h expected=no_byte", tag, rx_q.pop_front());
        end else begin
            checkOutput(tag, rx_q.pop_front(), exp_q.pop_front());
        end
    endtask

    task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input logic [7:0] expected, input string tag);
        applyStimulus(a, 10);
        applyStimulus(b, 10);
        applyStimulus(op, 10);
        exp_q.push_back(expected);
        waitResult(tag);
    endtask

    initial begin : stimulus
        int  cycles;
        logic seen_start;

        serial.rx = 1'b1;
        i_reset   = 1'b1;
        repeat (4) @(negedge i_clk);
        checkOutput("reset_tx_idle", {7'b0, serial.tx}, 8'h01);
        i_reset = 1'b0;
        repeat (40) @(negedge i_clk);
        checkOutput("post_reset_tx_idle", {7'b0, serial.tx}, 8'h01);

        runOp(8'h03, 8'h08, 8'h20, 8'h0B, "add_3_8");
        repeat (12 * BIT_CLKS) @(negedge i_clk);
        checkOutput("add_single_byte", 8'(rx_q.size()), 8'h00);

        runOp(8'h08, 8'h03, 8'h22, 8'h05, "sub_8_3");
        runOp(8'h03, 8'h08, 8'h22, 8'hFB, "sub_wrap");
        runOp(8'h80, 8'h02, 8'h03, 8'hE0, "sra_80_2");
        runOp(8'h80, 8'h02, 8'h02, 8'h20, "srl_80_2");
        runOp(8'h80, 8'h09, 8'h03, 8'hFF, "sra_over_width");
        runOp(8'h80, 8'h09, 8'h02, 8'h00, "srl_over_width");
        runOp(8'hF0, 8'h0F, 8'h24, 8'h00, "and_f0_0f");
        runOp(8'hF0, 8'h0F, 8'h25, 8'hFF, "or_f0_0f");
        runOp(8'hF0, 8'h0F, 8'h26, 8'hFF, "xor_f0_0f");
        runOp(8'hF0, 8'h0F, 8'h27, 8'h00, "nor_f0_0f");
        runOp(8'h05, 8'h06, 8'h3F, 8'h00, "unknown_op");
        runOp(8'hFF, 8'h01, 8'h20, 8'h00, "add_wrap_second_seq");
        runOp(8'h03, 8'h08, 8'hE0, 8'h0B, "add_upper_op_bits_ignored");

        // Reset in the middle of the B byte.
        applyStimulus(8'h03, 10);
        applyStimulus(8'h08, 5);
        i_reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            checkOutput("reset_mid_rx_tx_high", {7'b0, serial.tx}, 8'h01);
        end
        i_reset = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge i_clk);
        runOp(8'h03, 8'h08, 8'h20, 8'h0B, "add_after_rx_reset");

        // Reset while the result start bit is on the line.
        applyStimulus(8'h03, 10);
        applyStimulus(8'h08, 10);
        applyStimulus(8'h20, 10);
        cycles     = 0;
        seen_start = 1'b0;
        while (!seen_start && cycles < WAIT_MAX) begin
            @(negedge i_clk);
            seen_start = (serial.tx === 1'b0);
            cycles++;
        end
        checks++;
        assert (seen_start) else begin
            failures++;
            $error("[TB] FAIL tx_start_bit_seen observed=no_start_bit expected=start_bit_within_%0d_clocks", WAIT_MAX);
        end
        repeat (4) @(negedge i_clk);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        checkOutput("tx_abort_line_high", {7'b0, serial.tx}, 8'h01);
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (12 * BIT_CLKS) @(negedge i_clk);
        rx_q.delete();

        // One-clock low glitch while idle.
        serial.rx = 1'b0;
        @(negedge i_clk);
        serial.rx = 1'b1;
        repeat (12 * BIT_CLKS) @(negedge i_clk);
        checkOutput("glitch_no_byte", 8'(rx_q.size()), 8'h00);
        runOp(8'h03, 8'h08, 8'h20, 8'h0B, "add_after_glitch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
